alu_sequencer: RTL and testbench

Controller that sits in front of the signed 8-bit calculator ALU. It stages operands and opcode from the input side and launches an operation on a single go strobe. It drives the ALU inputs from registers, waits a programmable settle time for the combinational multiply/divide path, then captures the 16-bit result. It reports completion with a busy/done handshake, flags divide-by-zero, and supports chaining the previous result in as operand A.

---
 rtl/alu_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequencer in front of the signed 8-bit calculator ALU: stages operands and opcode,
// launches on go, waits a settle time for the combinational ALU path, then captures the result.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  key_data,
  input  logic        load_a,
  input  logic        load_b,
  input  logic [1:0]  op_in,
  input  logic        go,
  input  logic        chain,
  input  logic [15:0] alu_result,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        err_div0
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE_CYCLES);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r;
  logic [7:0]  stg_a_r, stg_b_r;
  logic [1:0]  stg_op_r;
  logic [7:0]  alu_a_r, alu_b_r;
  logic [1:0]  alu_op_r;
  logic [15:0] result_r;
  logic        busy_r, done_r, err_div0_r;

  logic        launch_s, capture_s;
  logic [7:0]  next_a_s, next_b_s;
  logic [1:0]  next_op_s;

  // Clamp a signed 16-bit result into the signed 8-bit operand range.
  function automatic logic [7:0] sat8(input logic [15:0] v);
    if (!v[15] && (v[14:7] != 8'h00)) begin
      return 8'h7f;
    end else if (v[15] && (v[14:7] != 8'hff)) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

  // Next-state decode; go is accepted in IDLE and at the edge that ends DONE.
  always_comb begin
    state_s   = state_r;
    launch_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (go) begin
          launch_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        capture_s = 1'b1;
        state_s   = ST_DONE;
      end
      ST_DONE: begin
        if (go) begin
          launch_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Staging values with same-cycle bypass; a chained launch replaces operand A.
  always_comb begin
    next_a_s  = stg_a_r;
    next_b_s  = stg_b_r;
    next_op_s = stg_op_r;
    if (launch_s && chain) begin
      next_a_s = sat8(result_r);
    end else if (load_a) begin
      next_a_s = key_data;
    end else begin
      next_a_s = stg_a_r;
    end
    if (load_b) begin
      next_b_s = key_data;
    end else begin
      next_b_s = stg_b_r;
    end
    if (load_a || load_b || go) begin
      next_op_s = op_in;
    end else begin
      next_op_s = stg_op_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Staging registers, updated in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_a_r  <= 8'h00;
      stg_b_r  <= 8'h00;
      stg_op_r <= 2'b00;
    end else begin
      stg_a_r  <= next_a_s;
      stg_b_r  <= next_b_s;
      stg_op_r <= next_op_s;
    end
  end

  // ALU drive registers, frozen from launch until the next launch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_r  <= 8'h00;
      alu_b_r  <= 8'h00;
      alu_op_r <= 2'b00;
    end else if (launch_s) begin
      alu_a_r  <= next_a_s;
      alu_b_r  <= next_b_s;
      alu_op_r <= next_op_s;
    end else begin
      alu_a_r  <= alu_a_r;
      alu_b_r  <= alu_b_r;
      alu_op_r <= alu_op_r;
    end
  end

  // Settle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (launch_s) begin
      cnt_r <= SETTLE_W;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture, error flag and handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r   <= 16'h0000;
      err_div0_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      done_r <= capture_s;
      if (capture_s) begin
        result_r   <= alu_result;
        err_div0_r <= (alu_op_r == 2'b11) && (alu_b_r == 8'h00);
      end else begin
        result_r   <= result_r;
        err_div0_r <= err_div0_r;
      end
      if (launch_s) begin
        busy_r <= 1'b1;
      end else if (state_r == ST_DONE) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign alu_a    = alu_a_r;
  assign alu_b    = alu_b_r;
  assign alu_op   = alu_op_r;
  assign result   = result_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err_div0 = err_div0_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus an operand/result model,
// directed scenarios from the test plan and a randomized operation sweep.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  key_data;
  logic        load_a, load_b, go, chain;
  logic [1:0]  op_in;

  logic [7:0]  a1, b1, a4, b4;
  logic [1:0]  op1, op4;
  logic [15:0] res1, res4, alu_res1, alu_res4;
  logic        busy1, done1, err1, busy4, done4, err4;

  logic        sel4;
  logic [7:0]  o_a, o_b;
  logic [1:0]  o_op;
  logic [15:0] o_res;
  logic        o_busy, o_done, o_err;

  int checks = 0;
  int failures = 0;

  logic [7:0]  m_a, m_b;
  logic [15:0] m_res;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = sa * sb;
      default: r = (sb == 0) ? 0 : (sa * 100) / sb;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [7:0] sat8(input logic [15:0] r);
    int v;
    v = $signed(r);
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return v[7:0];
  endfunction

  assign alu_res1 = alu_fn(a1, b1, op1);
  assign alu_res4 = alu_fn(a4, b4, op4);

  assign o_a    = sel4 ? a4    : a1;
  assign o_b    = sel4 ? b4    : b1;
  assign o_op   = sel4 ? op4   : op1;
  assign o_res  = sel4 ? res4  : res1;
  assign o_busy = sel4 ? busy4 : busy1;
  assign o_done = sel4 ? done4 : done1;
  assign o_err  = sel4 ? err4  : err1;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .key_data(key_data), .load_a(load_a), .load_b(load_b),
    .op_in(op_in), .go(go), .chain(chain), .alu_result(alu_res1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .result(res1),
    .busy(busy1), .done(done1), .err_div0(err1)
  );

  alu_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_data(key_data), .load_a(load_a), .load_b(load_b),
    .op_in(op_in), .go(go), .chain(chain), .alu_result(alu_res4),
    .alu_a(a4), .alu_b(b4), .alu_op(op4), .result(res4),
    .busy(busy4), .done(done4), .err_div0(err4)
  );

  task automatic model_reset();
    m_a = 8'h00;
    m_b = 8'h00;
    m_res = 16'h0000;
  endtask

  task automatic stage(input logic la, input logic lb, input logic [7:0] v);
    load_a = la;
    load_b = lb;
    key_data = v;
    @(negedge clk);
    if (la) m_a = v;
    if (lb) m_b = v;
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Launch one operation and follow it to completion against the model.
  task automatic run_op(input string name, input logic [1:0] op, input logic ch, input logic la,
                        input logic [7:0] v, input bit hold_go, input bit toggle);
    logic [7:0]  ea, eb;
    logic [15:0] er;
    logic        ediv;
    int          edges, settle;
    bit          seen;
    settle = sel4 ? 4 : 1;
    ea = ch ? sat8(m_res) : (la ? v : m_a);
    eb = m_b;
    er = alu_fn(ea, eb, op);
    ediv = (op == 2'b11) && (eb == 8'h00);
    go = 1'b1; op_in = op; chain = ch; load_a = la; key_data = v;
    @(negedge clk);
    go = hold_go; chain = 1'b0; load_a = 1'b0;
    m_a = ea;
    m_res = er;
    checks++;
    if ({o_a, o_b, o_op} !== {ea, eb, op}) begin
      failures++;
      $display("FAIL %s launch operands: got a=%h b=%h op=%b, want a=%h b=%h op=%b", name, o_a, o_b, o_op, ea, eb, op);
    end
    edges = 1;
    seen = 1'b0;
    while (!seen && edges < settle + 10) begin
      if (o_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (o_busy !== 1'b1 || {o_a, o_b, o_op} !== {ea, eb, op}) begin
          failures++;
          $display("FAIL %s hold edge %0d: got busy=%b a=%h b=%h op=%b, want busy=1 a=%h b=%h op=%b", name, edges, o_busy, o_a, o_b, o_op, ea, eb, op);
        end
        if (toggle) begin
          load_a = edges[0];
          load_b = !edges[0];
          key_data = 8'($urandom);
        end
        @(negedge clk);
        if (load_a) m_a = key_data;
        if (load_b) m_b = key_data;
        load_a = 1'b0;
        load_b = 1'b0;
        edges++;
      end
    end
    go = 1'b0;
    checks++;
    if (!seen || edges != settle + 2) begin
      failures++;
      $display("FAIL %s latency: got done=%b after %0d edges, want done after %0d edges", name, seen, edges, settle + 2);
    end
    checks++;
    if (o_res !== er || o_err !== ediv || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s result: got res=%h err=%b busy=%b, want res=%h err=%b busy=1", name, o_res, o_err, o_busy, er, ediv);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_res !== er || o_err !== ediv) begin
      failures++;
      $display("FAIL %s after done: got done=%b busy=%b res=%h err=%b, want done=0 busy=0 res=%h err=%b", name, o_done, o_busy, o_res, o_err, er, ediv);
    end
    if (hold_go) begin
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
          failures++;
          $display("FAIL %s extra launch: got done=%b busy=%b, want done=0 busy=0", name, o_done, o_busy);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a1, b1, op1, res1, busy1, done1, err1} !== 37'h0 || {a4, b4, op4, res4, busy4, done4, err4} !== 37'h0) begin
      failures++;
      $display("FAIL reset state: got dut1=%h dut4=%h, want 0", {a1, b1, op1, res1, busy1, done1, err1}, {a4, b4, op4, res4, busy4, done4, err4});
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_add();
    stage(1'b1, 1'b0, 8'd25);
    stage(1'b0, 1'b1, 8'hf6);
    run_op("add", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (res1 !== 16'd15) begin
      failures++;
      $display("FAIL add value: got %h, want %h", res1, 16'd15);
    end
  endtask

  task automatic test_mul_chain();
    stage(1'b1, 1'b1, 8'h80);
    run_op("mul_extreme", 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (res1 !== 16'd16384) begin
      failures++;
      $display("FAIL mul value: got %h, want %h", res1, 16'd16384);
    end
    stage(1'b0, 1'b1, 8'd1);
    run_op("chain_sat", 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (a1 !== 8'h7f || res1 !== 16'd128) begin
      failures++;
      $display("FAIL chain value: got a=%h res=%h, want a=7f res=%h", a1, res1, 16'd128);
    end
  endtask

  task automatic test_div();
    stage(1'b1, 1'b0, 8'd7);
    stage(1'b0, 1'b1, 8'd2);
    run_op("div_scaled", 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (res1 !== 16'd350 || err1 !== 1'b0) begin
      failures++;
      $display("FAIL div value: got res=%h err=%b, want res=%h err=0", res1, err1, 16'd350);
    end
    stage(1'b0, 1'b1, 8'd0);
    run_op("div_zero", 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (res1 !== 16'd0 || err1 !== 1'b1) begin
      failures++;
      $display("FAIL div0 flag: got res=%h err=%b, want res=0 err=1", res1, err1);
    end
    run_op("err_clear", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (err1 !== 1'b0) begin
      failures++;
      $display("FAIL err clear: got %b, want 0", err1);
    end
  endtask

  task automatic test_bypass_busy();
    stage(1'b0, 1'b1, 8'd3);
    run_op("bypass", 2'b01, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
    checks++;
    if (res1 !== 16'd2) begin
      failures++;
      $display("FAIL bypass value: got %h, want %h", res1, 16'd2);
    end
    run_op("go_while_busy", 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    stage(1'b1, 1'b1, 8'd9);
    go = 1'b1; op_in = 2'b10;
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("FAIL mid launch: got busy=%b, want 1", busy1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({a1, b1, op1, res1, busy1, done1, err1} !== 37'h0) begin
      failures++;
      $display("FAIL mid reset: got %h, want 0", {a1, b1, op1, res1, busy1, done1, err1});
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        failures++;
        $display("FAIL post reset idle: got done=%b busy=%b, want 0 0", done1, busy1);
      end
    end
    stage(1'b1, 1'b0, 8'd3);
    stage(1'b0, 1'b1, 8'd4);
    run_op("after_reset", 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_settle4();
    sel4 = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    stage(1'b1, 1'b0, 8'($urandom));
    stage(1'b0, 1'b1, 8'($urandom));
    run_op("settle4", 2'($urandom_range(0, 3)), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    sel4 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      stage(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      run_op("random", 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_data = 8'h00; load_a = 1'b0; load_b = 1'b0;
    op_in = 2'b00; go = 1'b0; chain = 1'b0; sel4 = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_add();
    test_mul_chain();
    test_div();
    test_bypass_busy();
    test_reset_mid();
    test_settle4();
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
